// File: rtl/rs232_recv.sv
// RS232/UART 8N1 receiver for the FT232 link: fractional phase-accumulator bit timing,
// single-entry valid/ready output buffer and CTS_n flow control.
module rs232_recv #(
  parameter int unsigned CLOCK_FREQ = 133000000,
  parameter int unsigned BAUD_RATE  = 12000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       cts_n,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ACC_W-1:0] ACC_INC  = ACC_W'(BAUD_RATE);
  localparam logic [ACC_W-1:0] ACC_MOD  = ACC_W'(CLOCK_FREQ);
  localparam logic [ACC_W-1:0] ACC_HALF = ACC_W'(CLOCK_FREQ / 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  if (CLOCK_FREQ < 4 * BAUD_RATE) begin : g_param_check
    $error("rs232_recv: CLOCK_FREQ must be at least 4*BAUD_RATE");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t              state, state_nxt;
  logic                rxd_meta, rxd_s;
  logic [ACC_W-1:0]    acc, acc_nxt, acc_sum;
  logic                tick;
  logic [CNT_W-1:0]    bitcnt, bitcnt_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                valid_nxt;
  logic                frame_error_nxt;
  logic                overrun_nxt;
  logic                store;

  // State, timing and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_meta    <= 1'b1;
      rxd_s       <= 1'b1;
      state       <= IDLE;
      acc         <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      cts_n       <= 1'b1;
    end else begin
      rxd_meta    <= rxd;
      rxd_s       <= rxd_meta;
      state       <= state_nxt;
      acc         <= acc_nxt;
      bitcnt      <= bitcnt_nxt;
      shreg       <= shreg_nxt;
      data        <= data_nxt;
      valid       <= valid_nxt;
      frame_error <= frame_error_nxt;
      overrun     <= overrun_nxt;
      cts_n       <= valid;
    end
  end

  // Next-state, bit timing and buffer control
  always_comb begin
    state_nxt       = state;
    acc_nxt         = acc;
    acc_sum         = acc + ACC_INC;
    tick            = 1'b0;
    bitcnt_nxt      = bitcnt;
    shreg_nxt       = shreg;
    data_nxt        = data;
    valid_nxt       = valid;
    frame_error_nxt = 1'b0;
    overrun_nxt     = 1'b0;
    store           = 1'b0;

    // Accumulator only runs while a frame is being timed
    if (state != IDLE && state != WAIT_HIGH) begin
      tick    = (acc_sum >= ACC_MOD);
      acc_nxt = tick ? (acc_sum - ACC_MOD) : acc_sum;
    end

    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt = START;
          acc_nxt   = ACC_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rxd_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt  = DATA;
            bitcnt_nxt = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nxt  = {rxd_s, shreg[DATA_W-1:1]};
          bitcnt_nxt = CNT_W'(bitcnt + 1'b1);
          if (bitcnt == LAST_BIT) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rxd_s) begin
            state_nxt = IDLE;
            store     = 1'b1;
          end else begin
            state_nxt       = WAIT_HIGH;
            frame_error_nxt = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Single-entry buffer: a store may overlap a consume, otherwise a full buffer drops the byte
    if (store) begin
      if (!valid || ready) begin
        data_nxt  = shreg;
        valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (valid && ready) begin
      valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_rs232_recv.sv
// Directed bench for rs232_recv: serial frames at fractional bit periods with
// hand-computed expectations checked by immediate assertions.
`timescale 1ns/1ps
module tb_rs232_recv;

  logic       clock;
  logic       reset;
  logic       rxd;
  logic       cts_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_error;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  int         rx_cnt    = 0;
  int         fe_cnt    = 0;
  int         ov_cnt    = 0;
  int         both_cnt  = 0;
  int         valid_cyc = 0;
  int         cts_cyc   = 0;
  logic [7:0] rx_log [256];

  int rx_base, fe_base, ov_base, valid_base, cts_base;

  localparam real CPB_NOM  = 133.0 / 12.0;
  localparam real CPB_FAST = 10.86;
  localparam real CPB_SLOW = 11.30;

  rs232_recv #(.CLOCK_FREQ(133000000), .BAUD_RATE(12000000)) dut (
    .clock       (clock),
    .reset       (reset),
    .rxd         (rxd),
    .cts_n       (cts_n),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #4 clock = ~clock;

  // Passive monitor on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && ready) begin
        rx_log[rx_cnt[7:0]] <= data;
        rx_cnt <= rx_cnt + 1;
      end
      if (frame_error) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (frame_error && overrun) both_cnt <= both_cnt + 1;
      if (valid) valid_cyc <= valid_cyc + 1;
      if (cts_n) cts_cyc <= cts_cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one frame; bit k covers clocks n with floor(n/cpb) == k. max_cycles < 0 sends it all.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real cpb,
                            input int max_cycles);
    logic [9:0] bits;
    int         len;
    int         idx;
    bits = {stop_bit, b, 1'b0};
    len  = int'($ceil(10.0 * cpb));
    if (max_cycles >= 0 && max_cycles < len) len = max_cycles;
    for (int n = 0; n < len; n++) begin
      idx = int'($floor(real'(n) / cpb));
      rxd = bits[idx];
      @(posedge clock);
      #1;
    end
  endtask

  task automatic mark();
    @(negedge clock);
    rx_base    = rx_cnt;
    fe_base    = fe_cnt;
    ov_base    = ov_cnt;
    valid_base = valid_cyc;
    cts_base   = cts_cyc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    rxd   = 1'b1;
    ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_cts_n", 32'(cts_n), 32'd1);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(20);
    check("idle_cts_n", 32'(cts_n), 32'd0);

    // Ideal timing
    mark();
    send_frame(8'h55, 1'b1, CPB_NOM, -1);
    idle(20);
    check("nom_count", 32'(rx_cnt - rx_base), 32'd1);
    check("nom_data", 32'(rx_log[rx_base[7:0]]), 32'h55);
    check("nom_fe", 32'(fe_cnt - fe_base), 32'd0);
    check("nom_ov", 32'(ov_cnt - ov_base), 32'd0);
    check("nom_valid_cyc", 32'(valid_cyc - valid_base), 32'd1);
    check("nom_cts_cyc", 32'(cts_cyc - cts_base), 32'd1);
    check("nom_cts_end", 32'(cts_n), 32'd0);

    // Glitch in idle, then a real frame shortly after
    mark();
    rxd = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    idle(12);
    check("glitch_count", 32'(rx_cnt - rx_base), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe_base), 32'd0);
    check("glitch_valid_cyc", 32'(valid_cyc - valid_base), 32'd0);
    send_frame(8'hA5, 1'b1, CPB_NOM, -1);
    idle(20);
    check("glitch_next_count", 32'(rx_cnt - rx_base), 32'd1);
    check("glitch_next_data", 32'(rx_log[rx_base[7:0]]), 32'hA5);

    // Framing error followed by a break
    mark();
    send_frame(8'hA5, 1'b0, CPB_NOM, -1);
    rxd = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
    end
    idle(20);
    check("frm_fe", 32'(fe_cnt - fe_base), 32'd1);
    check("frm_count", 32'(rx_cnt - rx_base), 32'd0);
    check("frm_valid_cyc", 32'(valid_cyc - valid_base), 32'd0);
    send_frame(8'h3C, 1'b1, CPB_NOM, -1);
    idle(20);
    check("frm_next_count", 32'(rx_cnt - rx_base), 32'd1);
    check("frm_next_data", 32'(rx_log[rx_base[7:0]]), 32'h3C);
    check("frm_next_fe", 32'(fe_cnt - fe_base), 32'd1);

    // Backpressure and overrun
    ready = 1'b0;
    mark();
    send_frame(8'h11, 1'b1, CPB_NOM, -1);
    idle(5);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_data", 32'(data), 32'h11);
    check("bp_cts_n", 32'(cts_n), 32'd1);
    send_frame(8'h22, 1'b1, CPB_NOM, -1);
    idle(5);
    check("bp_ov", 32'(ov_cnt - ov_base), 32'd1);
    check("bp_ov_data", 32'(data), 32'h11);
    check("bp_ov_valid", 32'(valid), 32'd1);
    check("bp_ov_fe", 32'(fe_cnt - fe_base), 32'd0);
    ready = 1'b1;
    @(posedge clock);
    #1 ready = 1'b0;
    check("bp_drain_valid", 32'(valid), 32'd0);
    @(posedge clock);
    #1;
    check("bp_drain_cts_n", 32'(cts_n), 32'd0);
    check("bp_drain_count", 32'(rx_cnt - rx_base), 32'd1);
    check("bp_drain_data", 32'(rx_log[rx_base[7:0]]), 32'h11);
    ready = 1'b1;
    idle(10);

    // Baud tolerance, back-to-back frames
    for (int r = 0; r < 2; r++) begin
      real        cpb;
      logic [7:0] pat [4];
      pat[0] = 8'h00;
      pat[1] = 8'hFF;
      pat[2] = 8'h80;
      pat[3] = 8'h01;
      cpb = (r == 0) ? CPB_FAST : CPB_SLOW;
      mark();
      for (int k = 0; k < 4; k++) send_frame(pat[k], 1'b1, cpb, -1);
      idle(20);
      check($sformatf("tol%0d_count", r), 32'(rx_cnt - rx_base), 32'd4);
      for (int k = 0; k < 4; k++)
        check($sformatf("tol%0d_byte%0d", r, k), 32'(rx_log[8'(rx_base + k)]), 32'(pat[k]));
      check($sformatf("tol%0d_fe", r), 32'(fe_cnt - fe_base), 32'd0);
      check($sformatf("tol%0d_ov", r), 32'(ov_cnt - ov_base), 32'd0);
    end

    // Reset during data bit 4
    mark();
    send_frame(8'hC3, 1'b1, CPB_NOM, 60);
    rxd   = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_cts_n", 32'(cts_n), 32'd1);
    check("mid_rst_fe", 32'(frame_error), 32'd0);
    check("mid_rst_ov", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(30);
    check("mid_rst_quiet_count", 32'(rx_cnt - rx_base), 32'd0);
    check("mid_rst_quiet_fe", 32'(fe_cnt - fe_base), 32'd0);
    check("mid_rst_quiet_cts_n", 32'(cts_n), 32'd0);
    send_frame(8'hC3, 1'b1, CPB_NOM, -1);
    idle(20);
    check("mid_rst_next_count", 32'(rx_cnt - rx_base), 32'd1);
    check("mid_rst_next_data", 32'(rx_log[rx_base[7:0]]), 32'hC3);
    check("mid_rst_next_fe", 32'(fe_cnt - fe_base), 32'd0);

    check("pulses_exclusive", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
